// File: rtl/csel_shift_pipe.sv
`default_nettype none
// ============================================================================
//  Module   : csel_shift_pipe
//  Purpose  : Three-stage elastic add/compare/select/shift datapath.
//             Per accepted transaction:
//                 d = a + b, e = a + c, f = a - b        (modulo 2^DW)
//                 g = (d < e) ? e : d                     (signed or unsigned)
//                 h = (d == e) ? f : g
//                 x = (h << (sh_amt + lt))[OW-1:0]
//                 z = (g >> (sh_amt + eq))[OW-1:0]        (logical shift)
//             Any effective shift amount >= DW yields zero.
//  Ports    : clk        - clock, rising edge
//             rst_n      - asynchronous reset, active low
//             in_valid   - a, b, c, sh_amt, cmp_signed are valid
//             in_ready   - stage 1 can accept (transfer on in_valid & in_ready)
//             a, b, c    - DW-bit operands
//             sh_amt     - SW-bit base shift amount
//             cmp_signed - 1: compare d,e as two's complement, 0: unsigned
//             out_valid  - x, z are valid
//             out_ready  - consumer accepts (transfer on out_valid & out_ready)
//             x, z       - OW-bit results
//  Revision : 1.0 - initial release
// ============================================================================
module csel_shift_pipe #(
    parameter int DW = 64,
    parameter int OW = DW / 2,
    parameter int SW = $clog2(DW)
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [DW-1:0] a,
    input  logic [DW-1:0] b,
    input  logic [DW-1:0] c,
    input  logic [SW-1:0] sh_amt,
    input  logic          cmp_signed,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [OW-1:0] x,
    output logic [OW-1:0] z
);

    // Effective shift amounts carry one extra bit so sh_amt + 1 never wraps.
    // SW = clog2(DW) guarantees DW fits in SW+1 bits.
    localparam logic [SW:0] c_SH_LIMIT = (SW + 1)'(DW);

    // ------------------------------------------------------------------
    // Stage 1 combinational front end (computed straight from the inputs)
    // ------------------------------------------------------------------
    logic [DW-1:0] w_d;
    logic [DW-1:0] w_e;
    logic [DW-1:0] w_f;
    logic          w_lt;
    logic          w_eq;

    assign w_d  = a + b;
    assign w_e  = a + c;
    assign w_f  = a - b;
    assign w_eq = (w_d == w_e);
    assign w_lt = cmp_signed ? ($signed(w_d) < $signed(w_e)) : (w_d < w_e);

    // ------------------------------------------------------------------
    // Elastic handshake: a stage may load when it is empty or when its
    // contents are moving on this cycle. The chain is evaluated from the
    // output back, so out_ready reaches in_ready combinationally and a
    // full pipe still sustains one transfer per cycle.
    // ------------------------------------------------------------------
    logic r_v1;
    logic r_v2;
    logic r_v3;
    logic w_ld1;
    logic w_ld2;
    logic w_ld3;

    assign w_ld3    = ~r_v3 | out_ready;
    assign w_ld2    = ~r_v2 | w_ld3;
    assign w_ld1    = ~r_v1 | w_ld2;
    assign in_ready = w_ld1;

    // ------------------------------------------------------------------
    // Stage 1 registers: d, e, f, lt, eq, sh_amt
    // ------------------------------------------------------------------
    logic [DW-1:0] r_d;
    logic [DW-1:0] r_e;
    logic [DW-1:0] r_f;
    logic          r_lt1;
    logic          r_eq1;
    logic [SW-1:0] r_sh1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v1  <= 1'b0;
            r_d   <= '0;
            r_e   <= '0;
            r_f   <= '0;
            r_lt1 <= 1'b0;
            r_eq1 <= 1'b0;
            r_sh1 <= '0;
        end else if (w_ld1) begin
            r_v1 <= in_valid;
            // Data only moves with a real transfer; bubbles leave it untouched.
            if (in_valid) begin
                r_d   <= w_d;
                r_e   <= w_e;
                r_f   <= w_f;
                r_lt1 <= w_lt;
                r_eq1 <= w_eq;
                r_sh1 <= sh_amt;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 2 registers: g (select), h (equal override), lt, eq, sh_amt
    // ------------------------------------------------------------------
    logic [DW-1:0] r_g;
    logic [DW-1:0] r_h;
    logic          r_lt2;
    logic          r_eq2;
    logic [SW-1:0] r_sh2;
    logic [DW-1:0] w_g;

    assign w_g = r_lt1 ? r_e : r_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v2  <= 1'b0;
            r_g   <= '0;
            r_h   <= '0;
            r_lt2 <= 1'b0;
            r_eq2 <= 1'b0;
            r_sh2 <= '0;
        end else if (w_ld2) begin
            r_v2 <= r_v1;
            if (r_v1) begin
                r_g   <= w_g;
                r_h   <= r_eq1 ? r_f : w_g;
                r_lt2 <= r_lt1;
                r_eq2 <= r_eq1;
                r_sh2 <= r_sh1;
            end
        end
    end

    // ------------------------------------------------------------------
    // Stage 3: saturating shifters feeding the output registers.
    // ------------------------------------------------------------------
    logic [SW:0] w_shx;
    logic [SW:0] w_shz;

    assign w_shx = {1'b0, r_sh2} + {{SW{1'b0}}, r_lt2};
    assign w_shz = {1'b0, r_sh2} + {{SW{1'b0}}, r_eq2};

    logic [OW-1:0] r_x;
    logic [OW-1:0] r_z;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_v3 <= 1'b0;
            r_x  <= '0;
            r_z  <= '0;
        end else if (w_ld3) begin
            r_v3 <= r_v2;
            if (r_v2) begin
                r_x <= OW'((w_shx >= c_SH_LIMIT) ? {DW{1'b0}} : (r_h << w_shx));
                r_z <= OW'((w_shz >= c_SH_LIMIT) ? {DW{1'b0}} : (r_g >> w_shz));
            end
        end
    end

    assign out_valid = r_v3;
    assign x         = r_x;
    assign z         = r_z;

endmodule
`default_nettype wire
